// File: rtl/iso14443a_pkg.sv
// Shared ISO/IEC 14443-A framing definitions: CRC_A constants, the tx frame
// encoder state set and the odd-parity helper used by the tx and rx paths.
package iso14443a_pkg;

  localparam logic [15:0] CRC_A_PRESET    = 16'h6363;
  localparam logic [15:0] CRC_A_POLY_REFL = 16'h8408;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DATA       = 3'd1,
    ST_PARITY     = 3'd2,
    ST_CRC_LO     = 3'd3,
    ST_CRC_LO_PAR = 3'd4,
    ST_CRC_HI     = 3'd5,
    ST_CRC_HI_PAR = 3'd6
  } enc_state_e;

  // Parity bit that makes the total number of ones (byte + parity) odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/crc_a.sv
// Bit-serial CRC_A (reflected, LSB-first) shared by the tx encoder and rx decoder.
// init has priority over en so a frame start always begins from the preset.
module crc_a
  import iso14443a_pkg::*;
#(
  parameter logic [15:0] PRESET    = CRC_A_PRESET,
  parameter logic [15:0] POLY_REFL = CRC_A_POLY_REFL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic        data_bit,
  output logic [15:0] crc
);

  logic fb;

  assign fb = crc[0] ^ data_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= PRESET;
    end else if (init) begin
      crc <= PRESET;
    end else if (en) begin
      crc <= (crc >> 1) ^ (fb ? POLY_REFL : 16'h0000);
    end
  end

endmodule

// File: rtl/tx_frame_encoder.sv
// ISO 14443-A tx framing: serialises bytes LSB first with odd parity, optional
// CRC_A trailer and short final bytes, handshaking bit-by-bit with the modulator.
//
// state         | meaning
// ST_IDLE       | no frame; waiting for a rising in_valid
// ST_DATA       | sending data bit bit_cnt of the current byte
// ST_PARITY     | sending odd parity of the current byte
// ST_CRC_LO     | sending crc[7:0] bit bit_cnt
// ST_CRC_LO_PAR | sending parity of crc[7:0]
// ST_CRC_HI     | sending crc[15:8] bit bit_cnt
// ST_CRC_HI_PAR | sending parity of crc[15:8]; final bit of the frame
module tx_frame_encoder
  import iso14443a_pkg::*;
#(
  parameter logic [15:0] CRC_PRESET    = CRC_A_PRESET,
  parameter logic [15:0] CRC_POLY_REFL = CRC_A_POLY_REFL
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic [2:0] in_data_bits,
  input  logic       in_valid,
  input  logic       in_last,
  input  logic       in_append_crc,
  output logic       in_req,
  output logic       out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_req,
  output logic       underflow
);

  enc_state_e state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic       last_q, last_d;
  logic [2:0] bits_q, bits_d;
  logic       append_q, append_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       in_req_q, in_req_d;
  logic       underflow_q, underflow_d;
  logic       in_valid_q;

  logic        crc_init;
  logic        crc_en;
  logic        crc_bit;
  logic [15:0] crc;
  logic [7:0]  crc_lo;
  logic [7:0]  crc_hi;

  logic consume;
  logic short_end;
  logic data_c;
  logic last_c;

  assign crc_lo    = crc[7:0];
  assign crc_hi    = crc[15:8];
  assign out_valid = (state_q != ST_IDLE);
  assign consume   = out_valid & out_req;
  // A partial final byte ends the frame on bit (bits-1); bits==0 means a full byte.
  assign short_end = last_q && (bits_q != 3'd0) && (bit_cnt_q == bits_q - 3'd1);

  assign out_data  = data_c;
  assign out_last  = last_c;
  assign in_req    = in_req_q;
  assign underflow = underflow_q;

  crc_a #(
    .PRESET    (CRC_PRESET),
    .POLY_REFL (CRC_POLY_REFL)
  ) u_crc (
    .clk      (clk),
    .rst      (rst),
    .init     (crc_init),
    .en       (crc_en),
    .data_bit (crc_bit),
    .crc      (crc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      byte_q      <= 8'h00;
      last_q      <= 1'b0;
      bits_q      <= 3'd0;
      append_q    <= 1'b0;
      bit_cnt_q   <= 3'd0;
      in_req_q    <= 1'b0;
      underflow_q <= 1'b0;
      in_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      last_q      <= last_d;
      bits_q      <= bits_d;
      append_q    <= append_d;
      bit_cnt_q   <= bit_cnt_d;
      in_req_q    <= in_req_d;
      underflow_q <= underflow_d;
      in_valid_q  <= in_valid;
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    last_d      = last_q;
    bits_d      = bits_q;
    append_d    = append_q;
    bit_cnt_d   = bit_cnt_q;
    in_req_d    = 1'b0;
    underflow_d = 1'b0;
    crc_init    = 1'b0;
    crc_en      = 1'b0;
    crc_bit     = 1'b0;
    data_c      = 1'b0;
    last_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Edge-qualified start so a source still holding in_valid after the
        // previous frame cannot retrigger.
        if (in_valid && !in_valid_q) begin
          byte_d    = in_data;
          last_d    = in_last;
          bits_d    = in_last ? in_data_bits : 3'd0;
          append_d  = in_append_crc;
          bit_cnt_d = 3'd0;
          in_req_d  = 1'b1;
          crc_init  = 1'b1;
          state_d   = ST_DATA;
        end
      end

      ST_DATA: begin
        data_c = byte_q[bit_cnt_q];
        last_c = short_end;
        if (consume) begin
          crc_en    = 1'b1;
          crc_bit   = byte_q[bit_cnt_q];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (short_end) begin
            state_d = ST_IDLE;
          end else if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
      end

      ST_PARITY: begin
        data_c = odd_parity(byte_q);
        last_c = last_q && !append_q;
        if (consume) begin
          if (!last_q) begin
            // The source has been presenting the next byte since the cycle
            // after the previous in_req; load it here or abort the frame.
            if (in_valid) begin
              byte_d    = in_data;
              last_d    = in_last;
              bits_d    = in_last ? in_data_bits : 3'd0;
              bit_cnt_d = 3'd0;
              in_req_d  = 1'b1;
              state_d   = ST_DATA;
            end else begin
              underflow_d = 1'b1;
              state_d     = ST_IDLE;
            end
          end else if (append_q) begin
            bit_cnt_d = 3'd0;
            state_d   = ST_CRC_LO;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_CRC_LO: begin
        data_c = crc_lo[bit_cnt_q];
        if (consume) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_CRC_LO_PAR;
          end
        end
      end

      ST_CRC_LO_PAR: begin
        data_c = odd_parity(crc_lo);
        if (consume) begin
          bit_cnt_d = 3'd0;
          state_d   = ST_CRC_HI;
        end
      end

      ST_CRC_HI: begin
        data_c = crc_hi[bit_cnt_q];
        if (consume) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_CRC_HI_PAR;
          end
        end
      end

      ST_CRC_HI_PAR: begin
        data_c = odd_parity(crc_hi);
        last_c = 1'b1;
        if (consume) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tx_frame_encoder.sv
// Bench for tx_frame_encoder: a byte source and randomly paced bit sink, with
// the expected bit stream built from byte rules and a byte-wise CRC_A model.
module tb_tx_frame_encoder;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic [2:0] in_data_bits;
  logic       in_valid;
  logic       in_last;
  logic       in_append_crc;
  logic       in_req;
  logic       out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_req;
  logic       underflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] frame[$];

  tx_frame_encoder dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_data_bits  (in_data_bits),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_append_crc (in_append_crc),
    .in_req        (in_req),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_last      (out_last),
    .out_req       (out_req),
    .underflow     (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Byte-wise CRC_A as in the ISO 14443-3 reference routine.
  function automatic logic [15:0] crc_ref(input int n);
    logic [15:0] c;
    logic [7:0]  ch;
    c = 16'h6363;
    for (int i = 0; i < n; i++) begin
      ch = frame[i] ^ c[7:0];
      ch = ch ^ {ch[3:0], 4'b0000};
      c  = (c >> 8) ^ ({8'h00, ch} << 8) ^ ({8'h00, ch} << 3) ^ ({8'h00, ch} >> 4);
    end
    return c;
  endfunction

  function automatic logic odd_par(input logic [7:0] b);
    return (($countones(b) % 2) == 0);
  endfunction

  task automatic drive_byte(input int idx, input int n, input int last_bits);
    logic [31:0] r;
    r = $urandom;
    in_data  = frame[idx];
    in_valid = 1'b1;
    in_last  = (idx == n - 1);
    in_data_bits  = (idx == n - 1) ? last_bits[2:0] : r[2:0];
    in_append_crc = r[8];
  endtask

  task automatic run_frame(input int n, input int last_bits, input logic with_crc,
                           input int gmin, input int gmax, input int drop_idx,
                           input int abort_bit);
    logic        exp_d[$];
    logic        exp_l[$];
    logic [7:0]  b;
    logic [15:0] c;
    logic        pend, fresh, started, done, held_d, held_l;
    int nb, n_ok, byte_idx, bit_idx, gap, budget, req_cnt, uf_cnt;

    n_ok = (drop_idx >= 0) ? drop_idx : n;
    for (int i = 0; i < n_ok; i++) begin
      b  = frame[i];
      nb = (i == n - 1 && last_bits != 0) ? last_bits : 8;
      for (int k = 0; k < nb; k++) begin
        exp_d.push_back(b[k]);
        exp_l.push_back(1'b0);
      end
      if (nb == 8) begin
        exp_d.push_back(odd_par(b));
        exp_l.push_back(1'b0);
      end
    end
    if (drop_idx < 0 && with_crc && last_bits == 0) begin
      c = crc_ref(n);
      for (int h = 0; h < 2; h++) begin
        b = (h == 0) ? c[7:0] : c[15:8];
        for (int k = 0; k < 8; k++) begin
          exp_d.push_back(b[k]);
          exp_l.push_back(1'b0);
        end
        exp_d.push_back(odd_par(b));
        exp_l.push_back(1'b0);
      end
    end
    if (drop_idx < 0) exp_l[exp_l.size() - 1] = 1'b1;

    in_valid = 1'b0;
    out_req  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    drive_byte(0, n, last_bits);
    in_append_crc = with_crc;

    byte_idx = 0; bit_idx = 0; req_cnt = 0; uf_cnt = 0;
    pend = 1'b0; fresh = 1'b1; started = 1'b0; done = 1'b0;
    held_d = 1'b0; held_l = 1'b0; gap = 0;
    budget = exp_d.size() * (gmax + 2) + 40;

    while (!done) begin
      @(posedge clk);
      #1;
      out_req = 1'b0;
      budget--;
      if (underflow) uf_cnt++;
      if (pend) begin
        pend = 1'b0;
        byte_idx++;
        if (byte_idx < n && byte_idx != drop_idx) begin
          drive_byte(byte_idx, n, last_bits);
        end else begin
          in_valid = 1'b0;
          in_last  = 1'b0;
        end
      end
      if (in_req) begin
        req_cnt++;
        pend = 1'b1;
      end

      if (bit_idx == exp_d.size()) begin
        check_val("end_out_valid", out_valid, 0);
        check_val("end_underflow", underflow, (drop_idx >= 0));
        done = 1'b1;
      end else if (out_valid) begin
        started = 1'b1;
        if (fresh) begin
          check_val($sformatf("bit%0d_data", bit_idx), out_data, exp_d[bit_idx]);
          check_val($sformatf("bit%0d_last", bit_idx), out_last, exp_l[bit_idx]);
          held_d = out_data;
          held_l = out_last;
          fresh  = 1'b0;
          gap    = $urandom_range(gmax, gmin);
          if (bit_idx == abort_bit) begin
            #2 rst = 1'b1;
            #1 check_val("rst_outputs_async", {in_req, out_data, out_valid, out_last, underflow}, 0);
            @(posedge clk);
            #1 check_val("rst_outputs_held", {in_req, out_data, out_valid, out_last, underflow}, 0);
            in_valid = 1'b0;
            in_last  = 1'b0;
            rst      = 1'b0;
            return;
          end
        end else begin
          check_val("stable_data", out_data, held_d);
          check_val("stable_last", out_last, held_l);
        end
        gap--;
        if (gap <= 0) begin
          out_req = 1'b1;
          fresh   = 1'b1;
          bit_idx++;
        end
      end else if (started) begin
        check_val("early_end_bits", bit_idx, exp_d.size());
        done = 1'b1;
      end
      if (!done && budget <= 0) begin
        check_val("timeout_bits", bit_idx, exp_d.size());
        done = 1'b1;
      end
    end

    out_req = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (underflow) uf_cnt++;
    end
    check_val("idle_out_valid", out_valid, 0);
    check_val("underflow_pulses", uf_cnt, (drop_idx >= 0) ? 1 : 0);
    check_val("in_req_count", req_cnt, n_ok);
  endtask

  task automatic rand_frame(input int n);
    frame.delete();
    for (int i = 0; i < n; i++) frame.push_back(8'($urandom));
  endtask

  initial begin
    int n;
    int lb;
    rst = 1'b1;
    in_data = 8'h00; in_data_bits = 3'd0; in_valid = 1'b0;
    in_last = 1'b0; in_append_crc = 1'b0; out_req = 1'b0;
    #23;
    check_val("reset_outputs", {in_req, out_data, out_valid, out_last, underflow}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 check_val("post_reset_outputs", {in_req, out_data, out_valid, out_last, underflow}, 0);

    frame = '{8'h00, 8'h00};
    run_frame(2, 0, 1'b1, 1, 4, -1, -1);

    frame = '{8'h50, 8'h00};
    run_frame(2, 0, 1'b1, 2, 6, -1, -1);

    frame = '{8'h26};
    run_frame(1, 7, 1'b1, 1, 3, -1, -1);

    n = $urandom_range(100, 1);
    rand_frame(n);
    run_frame(n, 0, 1'b0, 8, 24, -1, -1);

    n = $urandom_range(6, 1);
    rand_frame(n);
    run_frame(n, 0, 1'b0, 8, 256, -1, -1);

    for (int t = 0; t < 4; t++) begin
      n  = $urandom_range(20, 1);
      lb = $urandom_range(7, 0);
      rand_frame(n);
      run_frame(n, lb, 1'($urandom), 1, 3, -1, -1);
    end

    frame = '{8'hA5, 8'h3C};
    run_frame(2, 0, 1'b0, 1, 5, 1, -1);
    frame = '{8'h00, 8'h00};
    run_frame(2, 0, 1'b1, 1, 3, -1, -1);

    frame = '{8'h00, 8'h00};
    run_frame(2, 0, 1'b1, 1, 3, -1, 21);
    frame = '{8'h00, 8'h00};
    run_frame(2, 0, 1'b1, 1, 3, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_frame_encoder.md
Name: tx_frame_encoder

Overview:
- Byte-to-bit framing stage that sits directly upstream of the ISO/IEC 14443-2A tx bit modulator.
- Takes frame bytes from the ISO 14443-3/4 layer and serialises them LSB first.
- Inserts the odd parity bit after every full byte.
- Optionally appends CRC_A, two bytes, each followed by its parity bit.
- Supports short/bit-oriented final bytes, which carry no parity and no CRC.

Parameters:
- CRC_PRESET, 16'h6363, CRC_A preset value.
- CRC_POLY_REFL, 16'h8408, reflected CRC_A polynomial (x^16+x^12+x^5+1).

Ports:
- clk  in  1  system clock; one clock.
- rst  in  1  reset; asynchronous, active-high.
- in_data  in  8  frame byte, LSB transmitted first.
- in_data_bits  in  3  valid bits in the final byte; 0 means 8. Only sampled with in_last.
- in_valid  in  1  byte present; a rising edge while IDLE starts a frame.
- in_last  in  1  current byte is the final data byte.
- in_append_crc  in  1  append CRC_A; sampled with the first byte, held for the frame.
- in_req  out  1  one-cycle pulse: current byte consumed; source presents the next byte on the following cycle.
- out_data  out  1  current bit to the tx modulator.
- out_valid  out  1  out_data valid.
- out_last  out  1  out_data is the final bit of the frame.
- out_req  in  1  one-cycle pulse from tx: current bit consumed.
- underflow  out  1  one-cycle pulse: frame aborted because in_valid was low when a byte was needed.

Behaviour:
- Reset values: in_req=0, out_data=0, out_valid=0, out_last=0, underflow=0; state=IDLE; crc=CRC_PRESET.
- States: IDLE, DATA, PARITY, CRC_LO, CRC_LO_PAR, CRC_HI, CRC_HI_PAR.
- IDLE:
  - On in_valid=1, latch in_data, in_last, in_data_bits and in_append_crc.
  - Pulse in_req, clear bit_cnt, set crc=CRC_PRESET.
  - Go to DATA; out_valid=1 from the next cycle.
  - Latency from in_valid to out_valid is 1 clk.
- Bit handshake:
  - out_data/out_last stay stable while out_valid=1 and out_req=0.
  - On out_req with out_valid=1, the next bit appears on the following cycle.
  - out_req while out_valid=0 is ignored.
- DATA:
  - out_data = byte[bit_cnt]. On consume, the CRC is updated with that bit and bit_cnt++.
  - Last bit of a full byte (bit_cnt=7) → PARITY.
  - Partial final byte (in_last and in_data_bits≠0): after bit in_data_bits-1 the frame ends. No parity, no CRC; out_last=1 on that bit.
- PARITY:
  - out_data = ~^byte (odd parity: ones in byte + parity is odd).
  - On consume, one of three outcomes:
    - not last → load the next byte (pulse in_req) → DATA;
    - last with CRC → CRC_LO;
    - last without CRC → end.
  - out_last=1 on the final parity bit when there is no CRC.
- Next-byte sampling: in_data/in_valid/in_last are sampled on the cycle after in_req.
  - If in_valid=0 at that point: pulse underflow, drop out_valid, go to IDLE.
- CRC_LO/CRC_HI:
  - Transmit crc[7:0] then crc[15:8], each LSB first, each followed by its odd parity bit.
  - The CRC register is frozen after the last data bit.
  - out_last=1 on the CRC_HI parity bit.
- End of frame: after the out_last bit is consumed, out_valid=0 next cycle → IDLE.
  - Frame start requires in_valid to have been low for at least one cycle since the previous frame's last in_req.
- Simultaneous events: out_req in the same cycle as an internal state change is a normal consume.
- Reset mid-frame: all outputs drop immediately (asynchronous); no partial bit is completed.
- Bit counter width: 3 bits, wraps 7→0 only on transition to PARITY.

Decomposition:
- Shared package iso14443a_pkg:
  - CRC_A preset and polynomial constants;
  - frame encoder state enum;
  - function odd_parity(byte).
- Sub-module crc_a:
  - bit-serial CRC_A (inputs: clk, rst, init, en, bit; output: crc[15:0]);
  - reused later by the rx frame decoder.

Test Plan:
- Bytes {0x00,0x00}, CRC on → bits 0×8,1,0×8,1, then CRC bytes 0xA0,0x1E each with parity (A0→p=1, 1E→p=1); out_last on the 36th bit.
- HLTA {0x50,0x00}, CRC on → CRC bytes 0x57,0xCD appended; total 36 bits; out_last only on the final bit.
- Short frame REQA: 0x26, in_last=1, in_data_bits=7, CRC on → exactly 7 bits 0,1,1,0,0,1,0; no parity; no CRC; out_last on bit 7.
- 1..100 random full bytes, CRC off, random out_req spacing 8–256 clk → each byte followed by the correct odd parity; bit count = 9·N; stable outputs between out_req pulses.
- Source drops in_valid before the 2nd byte → underflow pulses once, out_valid=0 next cycle, block returns IDLE and accepts a fresh frame correctly.
- Assert rst during the CRC_LO bits → all outputs 0 while rst is high; the next frame's CRC starts from 0x6363 (verified by re-sending {0x00,0x00} → A0 1E).
